// File: rtl/dbus_wb_if_if.sv
// Wishbone-style bus between the data-side bus interface (master) and memory (slave).
interface dbus_wb_if_if #(
  parameter int N_ADDR = 32,
  parameter int N_DATA = 32
);
  logic [N_ADDR-1:0] adr;
  logic [N_DATA-1:0] dat_w;
  logic [N_DATA-1:0] dat_r;
  logic              we;
  logic [3:0]        sel;
  logic              stb;
  logic              cyc;
  logic              ack;

  modport master (output adr, dat_w, we, sel, stb, cyc, input dat_r, ack);
  modport slave  (input adr, dat_w, we, sel, stb, cyc, output dat_r, ack);
endinterface

// File: rtl/dbus_wb_if.sv
// MEM-stage data bus bridge: runs one Wishbone cycle per request, stalls the pipe
// until ack, and holds load data while MEM is frozen by another stage.
module dbus_wb_if #(
  parameter int N_ADDR    = 32,
  parameter int N_DATA    = 32,
  parameter int STALL_W   = 6,
  parameter int STALL_IDX = 4,
  parameter int TIMEOUT   = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               cpu_ce,
  input  logic [N_ADDR-1:0]  cpu_addr,
  input  logic [N_DATA-1:0]  cpu_wdata,
  input  logic               cpu_we,
  input  logic [3:0]         cpu_sel,
  output logic [N_DATA-1:0]  cpu_rdata,
  output logic               stall_req,
  output logic               bus_err,
  dbus_wb_if_if.master       wb
);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, WAIT_STALL} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [N_DATA-1:0]  rd_buf;
  logic               launch, drop, to_err, buf_ld, buf_clr;
  logic               mem_stall, hit_to;

  assign mem_stall = stall[STALL_IDX];
  // only the MEM-stage bit of the stall vector matters here
  wire unused_stall = ^stall;

  assign hit_to = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    drop      = 1'b0;
    to_err    = 1'b0;
    buf_ld    = 1'b0;
    buf_clr   = 1'b0;
    stall_req = 1'b0;
    cpu_rdata = '0;
    case (state)
      IDLE: begin
        stall_req = cpu_ce & ~flush;
        if (cpu_ce && !flush) begin
          launch    = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        // flush beats a same-cycle ack; ack beats a same-cycle timeout
        if (flush) begin
          drop      = 1'b1;
          state_nxt = IDLE;
        end else if (wb.ack) begin
          drop      = 1'b1;
          cpu_rdata = wb.we ? '0 : wb.dat_r;
          if (mem_stall) begin
            buf_ld    = 1'b1;
            state_nxt = WAIT_STALL;
          end else begin
            state_nxt = IDLE;
          end
        end else if (hit_to) begin
          drop      = 1'b1;
          to_err    = 1'b1;
          state_nxt = IDLE;
        end else begin
          stall_req = 1'b1;
        end
      end
      WAIT_STALL: begin
        cpu_rdata = rd_buf;
        if (!mem_stall || flush) begin
          buf_clr   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb.adr   <= '0;
      wb.dat_w <= '0;
      wb.we    <= 1'b0;
      wb.sel   <= '0;
      wb.stb   <= 1'b0;
      wb.cyc   <= 1'b0;
      cnt      <= '0;
      rd_buf   <= '0;
      bus_err  <= 1'b0;
    end else begin
      bus_err <= to_err;
      if (launch) begin
        wb.adr   <= cpu_addr;
        wb.dat_w <= cpu_wdata;
        wb.we    <= cpu_we;
        wb.sel   <= cpu_sel;
        wb.stb   <= 1'b1;
        wb.cyc   <= 1'b1;
        cnt      <= '0;
      end else if (drop) begin
        wb.adr   <= '0;
        wb.dat_w <= '0;
        wb.we    <= 1'b0;
        wb.sel   <= '0;
        wb.stb   <= 1'b0;
        wb.cyc   <= 1'b0;
      end else if (state == BUSY && cnt != '1) begin
        cnt <= cnt + 1'b1;
      end
      if (buf_ld)       rd_buf <= cpu_rdata;
      else if (buf_clr) rd_buf <= '0;
    end
  end
endmodule

// File: tb/tb_dbus_wb_if.sv
// Bench for dbus_wb_if: expected bus transactions queued at request time, popped
// when cyc rises; CPU-side results checked cycle by cycle.
module tb_dbus_wb_if;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  stall;
  logic        flush, ce, we;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  sel;
  logic        stall_req, bus_err;
  int          n_chk = 0;
  int          n_fail = 0;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    logic [3:0]  sel;
  } txn_t;

  txn_t exp_q[$];
  txn_t cur;
  logic cyc_q = 1'b0;

  dbus_wb_if_if #(.N_ADDR(32), .N_DATA(32)) wb ();

  dbus_wb_if #(.N_ADDR(32), .N_DATA(32), .STALL_W(6), .STALL_IDX(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .cpu_ce(ce), .cpu_addr(addr), .cpu_wdata(wdata), .cpu_we(we), .cpu_sel(sel),
    .cpu_rdata(rdata), .stall_req(stall_req), .bus_err(bus_err), .wb(wb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic w, input logic [3:0] s);
    ce = 1'b1; addr = a; wdata = d; we = w; sel = s;
    exp_q.push_back({a, d, w, s});
  endtask

  // bus monitor: each new cycle must match the oldest queued request
  always @(negedge clk) begin
    if (wb.cyc && !cyc_q) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_cyc", {31'b0, wb.cyc}, 32'd0);
      end else begin
        cur = exp_q.pop_front();
        chk("bus_adr", wb.adr, cur.adr);
        chk("bus_dat", wb.dat_w, cur.dat);
        chk("bus_we", {31'b0, wb.we}, {31'b0, cur.we});
        chk("bus_sel", {28'b0, wb.sel}, {28'b0, cur.sel});
        chk("bus_stb", {31'b0, wb.stb}, 32'd1);
      end
    end else if (wb.cyc) begin
      chk("bus_adr_stable", wb.adr, cur.adr);
    end
    cyc_q = wb.cyc;
  end

  initial begin
    rst_n = 1'b0; stall = '0; flush = 1'b0; ce = 1'b0; we = 1'b0;
    addr = '0; wdata = '0; sel = '0; wb.ack = 1'b0; wb.dat_r = '0;
    tick; tick;
    #1;
    chk("rst_cyc", {31'b0, wb.cyc}, 32'd0);
    chk("rst_stb", {31'b0, wb.stb}, 32'd0);
    chk("rst_adr", wb.adr, 32'd0);
    chk("rst_dat", wb.dat_w, 32'd0);
    chk("rst_we_sel", {27'b0, wb.we, wb.sel}, 32'd0);
    chk("rst_stall_req", {31'b0, stall_req}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_bus_err", {31'b0, bus_err}, 32'd0);
    rst_n = 1'b1;

    // T1 read, ack on second bus cycle
    tick; issue(32'h100, 32'h0, 1'b0, 4'hF); #1;
    chk("t1_req_stall", {31'b0, stall_req}, 32'd1);
    chk("t1_req_nocyc", {31'b0, wb.cyc}, 32'd0);
    tick; #1;
    chk("t1_busy_stall", {31'b0, stall_req}, 32'd1);
    chk("t1_busy_cyc", {31'b0, wb.cyc}, 32'd1);
    tick; ce = 1'b0; wb.ack = 1'b1; wb.dat_r = 32'hDEADBEEF; #1;
    chk("t1_ack_rdata", rdata, 32'hDEADBEEF);
    chk("t1_ack_stall", {31'b0, stall_req}, 32'd0);
    tick; wb.ack = 1'b0; wb.dat_r = 32'h0; #1;
    chk("t1_done_cyc", {31'b0, wb.cyc}, 32'd0);
    chk("t1_done_rdata", rdata, 32'd0);

    // T2 write
    tick; issue(32'h204, 32'h12345678, 1'b1, 4'b0011);
    tick; #1;
    chk("t2_busy_stall", {31'b0, stall_req}, 32'd1);
    tick; ce = 1'b0; wb.ack = 1'b1; wb.dat_r = 32'hFFFFFFFF; #1;
    chk("t2_ack_rdata", rdata, 32'd0);
    chk("t2_ack_stall", {31'b0, stall_req}, 32'd0);
    tick; wb.ack = 1'b0; #1;
    chk("t2_done_cyc", {31'b0, wb.cyc}, 32'd0);
    chk("t2_done_we_sel", {27'b0, wb.we, wb.sel}, 32'd0);

    // T3 read data held while MEM stays stalled
    tick; issue(32'h300, 32'h0, 1'b0, 4'hF);
    tick;
    tick; ce = 1'b0; wb.ack = 1'b1; wb.dat_r = 32'hA5A5A5A5; stall = 6'b010000; #1;
    chk("t3_ack_rdata", rdata, 32'hA5A5A5A5);
    chk("t3_ack_stall", {31'b0, stall_req}, 32'd0);
    tick; wb.ack = 1'b0; wb.dat_r = 32'h5A5A5A5A; #1;
    chk("t3_hold1_rdata", rdata, 32'hA5A5A5A5);
    chk("t3_hold1_stall", {31'b0, stall_req}, 32'd0);
    chk("t3_hold1_cyc", {31'b0, wb.cyc}, 32'd0);
    tick; #1;
    chk("t3_hold2_rdata", rdata, 32'hA5A5A5A5);
    tick; stall = '0; #1;
    chk("t3_release_rdata", rdata, 32'hA5A5A5A5);
    tick; wb.dat_r = 32'h0; #1;
    chk("t3_idle_rdata", rdata, 32'd0);
    chk("t3_idle_stall", {31'b0, stall_req}, 32'd0);

    // T4 flush beats ack; flush in IDLE blocks a request
    tick; issue(32'h400, 32'h0, 1'b0, 4'hF);
    tick; ce = 1'b0; flush = 1'b1; wb.ack = 1'b1; wb.dat_r = 32'h11112222; #1;
    chk("t4_flush_rdata", rdata, 32'd0);
    chk("t4_flush_stall", {31'b0, stall_req}, 32'd0);
    tick; flush = 1'b0; wb.ack = 1'b0; wb.dat_r = 32'h0; #1;
    chk("t4_dropped_cyc", {31'b0, wb.cyc}, 32'd0);
    ce = 1'b1; addr = 32'h444; flush = 1'b1; #1;
    chk("t4_idle_flush_stall", {31'b0, stall_req}, 32'd0);
    tick; #1;
    chk("t4_idle_flush_cyc", {31'b0, wb.cyc}, 32'd0);
    tick; ce = 1'b0; flush = 1'b0; #1;
    chk("t4_idle_flush_cyc2", {31'b0, wb.cyc}, 32'd0);

    // T5 timeout: request cycle + 7 stalled BUSY cycles, abort on the 8th
    tick; issue(32'h500, 32'h0, 1'b0, 4'hF); #1;
    chk("t5_req_stall", {31'b0, stall_req}, 32'd1);
    for (int i = 0; i < 7; i++) begin
      tick; #1;
      chk("t5_busy_stall", {31'b0, stall_req}, 32'd1);
      chk("t5_busy_err", {31'b0, bus_err}, 32'd0);
    end
    tick; ce = 1'b0; #1;
    chk("t5_abort_stall", {31'b0, stall_req}, 32'd0);
    chk("t5_abort_cyc", {31'b0, wb.cyc}, 32'd1);
    tick; #1;
    chk("t5_err_pulse", {31'b0, bus_err}, 32'd1);
    chk("t5_err_cyc", {31'b0, wb.cyc}, 32'd0);
    tick; #1;
    chk("t5_err_clear", {31'b0, bus_err}, 32'd0);

    // T6 reset mid-cycle, then a late ack
    tick; issue(32'h600, 32'hCAFEF00D, 1'b1, 4'hC);
    tick; rst_n = 1'b0; #1;
    chk("t6_busy_cyc", {31'b0, wb.cyc}, 32'd1);
    tick; rst_n = 1'b1; ce = 1'b0; wb.ack = 1'b1; wb.dat_r = 32'h77777777; #1;
    chk("t6_rst_cyc", {31'b0, wb.cyc}, 32'd0);
    chk("t6_rst_adr", wb.adr, 32'd0);
    chk("t6_rst_dat", wb.dat_w, 32'd0);
    chk("t6_late_ack_rdata", rdata, 32'd0);
    chk("t6_late_ack_stall", {31'b0, stall_req}, 32'd0);
    tick; wb.ack = 1'b0; #1;
    chk("t6_after_cyc", {31'b0, wb.cyc}, 32'd0);
    chk("t6_after_err", {31'b0, bus_err}, 32'd0);

    tick;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
